// File: rtl/if_pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Optional exception redirect is controlled by the IF_PC_EXC_EN macro
// in the files that import this package.
package if_pc_pkg;

  // Fetch sequencing states: reset, normal fetch, stalled with a redirect pending.
  typedef enum logic [1:0] {
    RST_S  = 2'd0,
    RUN_S  = 2'd1,
    HOLD_S = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'hBFC0_0000;
  localparam int          PC_STEP      = 4;

  // Number of low PC bits that must be zero for an aligned fetch.
  function automatic int pc_align_w(input int step);
    int w;
    w = 0;
    while ((1 << w) < step) w = w + 1;
    return w;
  endfunction

  localparam int PC_ALIGN_W = pc_align_w(PC_STEP);

endpackage

// File: rtl/if_pc_redirect_buf.sv
// Pending-redirect buffer: remembers the most recent branch target that
// arrived while fetch was stalled. Load wins over clear if both are asserted.
module if_pc_redirect_buf
  import if_pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_target
);

  logic              valid_reg;
  logic [ADDR_W-1:0] target_reg;

  // Capture a new target on load (last one wins), drop it on clear or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      target_reg <= '0;
    end else if (load) begin
      valid_reg  <= 1'b1;
      target_reg <= target;
    end else if (clear) begin
      valid_reg  <= 1'b0;
      target_reg <= '0;
    end
  end

  assign pend_valid  = valid_reg;
  assign pend_target = target_reg;

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage program counter: sequential fetch, stall hold, branch/jump
// redirect, and buffering of branches that arrive during a stall.
// Define IF_PC_EXC_EN to add the exception redirect ports and logic.
module if_pc_gen
  import if_pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int                STEP      = PC_STEP   // power of two
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_i,
  input  logic              if_br_taken_i,
  input  logic [ADDR_W-1:0] if_br_target_i,
`ifdef IF_PC_EXC_EN
  input  logic              if_exc_i,
  input  logic [ADDR_W-1:0] if_exc_vec_i,
`endif
  output logic              if_pc_ce_o,
  output logic [ADDR_W-1:0] if_cur_pc_o,
  output logic [ADDR_W-1:0] if_next_pc_o,
  output logic              if_redirect_o,
  output logic              if_misalign_o
);

  localparam int ALIGN_W = pc_align_w(STEP);

  pc_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              ce_reg, ce_next;
  logic              redirect_reg, redirect_next;
  logic [ADDR_W-1:0] pc_seq;

  logic              buf_load, buf_clear;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_target;

  // Sequential successor wraps naturally at the top of the address space.
  assign pc_seq = pc_reg + ADDR_W'(STEP);

  if_pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load),
    .clear       (buf_clear),
    .target      (if_br_target_i),
    .pend_valid  (buf_valid),
    .pend_target (buf_target)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RST_S;
    else     state_reg <= state_next;
  end

  // Next-state: enter HOLD_S on a stalled branch, leave it on stall release
  // (or immediately on an exception).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST_S: state_next = RUN_S;
      RUN_S: begin
`ifdef IF_PC_EXC_EN
        if (if_exc_i) state_next = RUN_S;
        else
`endif
        if (if_br_taken_i && if_stall_i) state_next = HOLD_S;
      end
      HOLD_S: begin
`ifdef IF_PC_EXC_EN
        if (if_exc_i) state_next = RUN_S;
        else
`endif
        if (!if_stall_i) state_next = RUN_S;
      end
      default: state_next = RST_S;
    endcase
  end

  // Output/datapath decode: choose the next PC and drive the buffer controls.
  always_comb begin
    pc_next       = pc_reg;
    ce_next       = ce_reg;
    redirect_next = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    case (state_reg)
      RST_S: begin
        pc_next   = RESET_VEC;
        ce_next   = 1'b1;
        buf_clear = 1'b1;
      end
      RUN_S: begin
`ifdef IF_PC_EXC_EN
        if (if_exc_i) begin
          pc_next       = if_exc_vec_i;
          redirect_next = 1'b1;
          buf_clear     = 1'b1;
        end else
`endif
        if (if_br_taken_i) begin
          if (if_stall_i) begin
            buf_load = 1'b1;
          end else begin
            pc_next       = if_br_target_i;
            redirect_next = 1'b1;
          end
        end else if (!if_stall_i) begin
          pc_next = pc_seq;
        end
      end
      HOLD_S: begin
`ifdef IF_PC_EXC_EN
        if (if_exc_i) begin
          pc_next       = if_exc_vec_i;
          redirect_next = 1'b1;
          buf_clear     = 1'b1;
        end else
`endif
        if (if_stall_i) begin
          buf_load = if_br_taken_i;
        end else begin
          // A live branch in the release cycle is younger than the buffered one.
          buf_clear = 1'b1;
          if (if_br_taken_i) begin
            pc_next       = if_br_target_i;
            redirect_next = 1'b1;
          end else if (buf_valid) begin
            pc_next       = buf_target;
            redirect_next = 1'b1;
          end else begin
            pc_next = pc_seq;
          end
        end
      end
      default: begin
        pc_next = pc_reg;
      end
    endcase
  end

  // PC, chip enable and redirect pulse are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= '0;
      ce_reg       <= 1'b0;
      redirect_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      ce_reg       <= ce_next;
      redirect_reg <= redirect_next;
    end
  end

  assign if_pc_ce_o    = ce_reg;
  assign if_cur_pc_o   = pc_reg;
  assign if_next_pc_o  = pc_seq;
  assign if_redirect_o = redirect_reg;

  // Alignment flag only; a byte step has no alignment requirement.
  generate
    if (ALIGN_W > 0) begin : g_misalign
      assign if_misalign_o = |pc_reg[ALIGN_W-1:0];
    end else begin : g_no_misalign
      assign if_misalign_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen with a rule-level reference model that is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_if_pc_gen;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
`ifdef IF_PC_EXC_EN
  logic        exc;
  logic [31:0] vec;
`endif
  logic        ce;
  logic [31:0] cur_pc;
  logic [31:0] next_pc;
  logic        redir;
  logic        misal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_i     (stall),
    .if_br_taken_i  (br),
    .if_br_target_i (tgt),
`ifdef IF_PC_EXC_EN
    .if_exc_i       (exc),
    .if_exc_vec_i   (vec),
`endif
    .if_pc_ce_o     (ce),
    .if_cur_pc_o    (cur_pc),
    .if_next_pc_o   (next_pc),
    .if_redirect_o  (redir),
    .if_misalign_o  (misal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch PC must be, from the redirect rules.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_ce, m_redir, m_pend, m_live, m_valid;
  bit          m_exc;
  logic [31:0] m_vec;

  always @(posedge clk) begin
    m_exc = 1'b0;
    m_vec = '0;
`ifdef IF_PC_EXC_EN
    m_exc = exc;
    m_vec = vec;
`endif
    m_redir = 1'b0;
    if (rst) begin
      m_pc = '0; m_ce = 1'b0; m_pend = 1'b0; m_live = 1'b0;
    end else if (!m_live) begin
      m_pc = RV; m_ce = 1'b1; m_live = 1'b1;
    end else if (m_exc) begin
      m_pc = m_vec; m_redir = 1'b1; m_pend = 1'b0;
    end else if (br && !stall) begin
      m_pc = tgt; m_redir = 1'b1; m_pend = 1'b0;
    end else if (br && stall) begin
      m_pend = 1'b1; m_tgt = tgt;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_pend) begin
      m_pc = m_tgt; m_redir = 1'b1; m_pend = 1'b0;
    end else begin
      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cur_pc",   cur_pc,  m_pc);
      chk("ce",       32'(ce), 32'(m_ce));
      chk("redirect", 32'(redir), 32'(m_redir));
      chk("next_pc",  next_pc, 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000));
      chk("misalign", 32'(misal), 32'((m_pc % 4) != 0));
    end
  end

  // One transaction: apply inputs, let one edge sample them, report the result.
  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t, input string lbl);
    rst = r; stall = s; br = b; tgt = t;
    @(posedge clk);
    #1;
    $display("[%0t] %-10s rst=%0b stall=%0b br=%0b tgt=%h -> ce=%0b pc=%h redir=%0b mis=%0b",
             $time, lbl, r, s, b, t, ce, cur_pc, redir, misal);
  endtask

`ifdef IF_PC_EXC_EN
  task automatic cyc_exc(input bit s, input logic [31:0] v, input string lbl);
    exc = 1'b1; vec = v;
    cyc(1'b0, s, 1'b0, 32'h0, lbl);
    exc = 1'b0; vec = '0;
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
`ifdef IF_PC_EXC_EN
    exc = 1'b0; vec = '0;
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("lit_rst_ce", 32'(ce), 32'h0);
    chk("lit_rst_pc", cur_pc, 32'h0);
    chk("lit_rst_npc", next_pc, 32'h4);
    chk("lit_rst_redir", 32'(redir), 32'h0);

    // Reset release and sequential fetch.
    cyc(0, 0, 0, 0, "release");
    chk("lit_first_pc", cur_pc, 32'hBFC0_0000);
    chk("lit_first_ce", 32'(ce), 32'h1);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_seq1", cur_pc, 32'hBFC0_0004);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_seq2", cur_pc, 32'hBFC0_0008);

    // Branch redirect.
    cyc(0, 0, 1, 32'h8000_0100, "branch");
    chk("lit_br_pc", cur_pc, 32'h8000_0100);
    chk("lit_br_redir", 32'(redir), 32'h1);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_br_next", cur_pc, 32'h8000_0104);
    chk("lit_br_pulse", 32'(redir), 32'h0);

    // Branches buffered during a 4-cycle stall; last one wins.
    cyc(0, 1, 0, 0, "stall");
    cyc(0, 1, 1, 32'h100, "stall_br");
    cyc(0, 1, 1, 32'h200, "stall_br");
    cyc(0, 1, 0, 0, "stall");
    chk("lit_hold_pc", cur_pc, 32'h8000_0104);
    chk("lit_hold_ce", 32'(ce), 32'h1);
    cyc(0, 0, 0, 0, "release");
    chk("lit_buf_pc", cur_pc, 32'h200);
    chk("lit_buf_redir", 32'(redir), 32'h1);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_buf_next", cur_pc, 32'h204);

    // Live branch in the release cycle beats the buffered one.
    cyc(0, 1, 1, 32'h300, "stall_br");
    cyc(0, 0, 1, 32'h400, "live_br");
    chk("lit_live_pc", cur_pc, 32'h400);
    cyc(0, 0, 0, 0, "seq");

`ifdef IF_PC_EXC_EN
    // Exception during a stall with a pending branch discards the branch.
    cyc(0, 1, 1, 32'h500, "stall_br");
    cyc_exc(1, 32'hBFC0_0380, "exc");
    chk("lit_exc_pc", cur_pc, 32'hBFC0_0380);
    chk("lit_exc_redir", 32'(redir), 32'h1);
    cyc(0, 1, 0, 0, "stall");
    cyc(0, 0, 0, 0, "release");
    chk("lit_exc_drop", cur_pc, 32'hBFC0_0384);
`endif

    // Wrap at the top of the address space.
    cyc(0, 0, 1, 32'hFFFF_FFF8, "branch");
    cyc(0, 0, 0, 0, "seq");
    chk("lit_top_pc", cur_pc, 32'hFFFF_FFFC);
    chk("lit_top_npc", next_pc, 32'h0);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_wrap_pc", cur_pc, 32'h0);

    // Misaligned target is loaded unmodified and flagged.
    cyc(0, 0, 1, 32'h0000_0102, "branch");
    chk("lit_mis_pc", cur_pc, 32'h102);
    chk("lit_mis_flag", 32'(misal), 32'h1);
    cyc(0, 0, 0, 0, "seq");

    // Reset while a redirect is pending.
    cyc(0, 1, 1, 32'h700, "stall_br");
    cyc(1, 1, 0, 0, "reset");
    chk("lit_mid_rst_pc", cur_pc, 32'h0);
    chk("lit_mid_rst_ce", 32'(ce), 32'h0);
    cyc(0, 0, 0, 0, "release");
    chk("lit_mid_rel_pc", cur_pc, 32'hBFC0_0000);
    cyc(0, 0, 0, 0, "seq");
    chk("lit_mid_seq", cur_pc, 32'hBFC0_0004);
    cyc(0, 0, 0, 0, "seq");

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
